// File: rtl/imem_fetch_port.sv
// Instruction memory with a single-outstanding valid/ready fetch port, fixed wait states and a program-load write port.
// Optional build macro IMEM_MISALIGN_TRAP_EN: misaligned fetch addresses return INIT_WORD with rsp_err set.
module imem_fetch_port #(
    parameter int unsigned       DEPTH     = 1024,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       LATENCY   = 1,
    parameter logic [DATA_W-1:0] INIT_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned MEM_AW = $clog2(DEPTH);
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;

    // Program store has no reset: contents survive rst_n and start as INIT_WORD.
    logic [DATA_W-1:0]  mem_q [DEPTH] = '{default: INIT_WORD};

    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   prog_idx;
    logic               req_fault;
    logic               prog_in_range;
    logic [DATA_W-1:0]  rd_word;
    logic               unused_addr_bits;

    assign req_idx          = req_addr[ADDR_W-1:2];
    assign prog_idx         = prog_addr[ADDR_W-1:2];
    assign prog_in_range    = (prog_idx < DEPTH_IDX);
    assign rd_word          = mem_q[req_idx[MEM_AW-1:0]];
    assign unused_addr_bits = ^{req_addr[1:0], prog_addr[1:0]};

`ifdef IMEM_MISALIGN_TRAP_EN
    assign req_fault = (req_idx >= DEPTH_IDX) || (req_addr[1:0] != 2'b00);
`else
    assign req_fault = (req_idx >= DEPTH_IDX);
`endif

    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
            mem_q[prog_idx[MEM_AW-1:0]] <= prog_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = err_q;
        req_ready = (state_q == S_IDLE) && !flush;

        case (state_q)
            S_IDLE: begin
                // Read word is latched on the accept edge, so a same-edge write cannot reach it.
                if (req_valid && req_ready) begin
                    data_d = req_fault ? INIT_WORD : rd_word;
                    err_d  = req_fault;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (flush || rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule
